// File: rtl/mmap_apb_bridge_n.sv
// rtl/mmap_apb_bridge_n.sv - mmap valid/ready to APB4 bridge for SLV_NUM slaves
// Base/shift decode, decode-miss/PSLVERR/timeout errors, sticky error capture with IRQ.
module mmap_apb_bridge_n #(
  parameter int unsigned SLV_NUM     = 8,
  parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
  parameter int unsigned SLV_SHIFT   = 12,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    mmap_valid_i,
  input  logic [31:0]             mmap_addr_i,
  input  logic [31:0]             mmap_wdata_i,
  input  logic [3:0]              mmap_wstrb_i,
  output logic [31:0]             mmap_rdata_o,
  output logic                    mmap_ready_o,
  output logic                    mmap_err_o,
  output logic [31:0]             apb_paddr_o,
  output logic [2:0]              apb_pprot_o,
  output logic [SLV_NUM-1:0]      apb_psel_o,
  output logic                    apb_penable_o,
  output logic                    apb_pwrite_o,
  output logic [31:0]             apb_pwdata_o,
  output logic [3:0]              apb_pstrb_o,
  input  logic [SLV_NUM-1:0]      apb_pready_i,
  input  logic [32*SLV_NUM-1:0]   apb_prdata_i,
  input  logic [SLV_NUM-1:0]      apb_pslverr_i,
  input  logic                    err_clr_i,
  output logic                    err_valid_o,
  output logic [1:0]              err_cause_o,
  output logic [31:0]             err_addr_o
);

  localparam int unsigned IDX_W = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
  localparam logic [SLV_NUM-1:0] SEL_ONE = SLV_NUM'(1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  state_e state_q, state_d;

  logic [31:0]        off, idx_full;
  logic               hit;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        paddr_q, pwdata_q, rdata_q, tcnt_q, err_addr_q;
  logic [3:0]         pstrb_q;
  logic               pwrite_q, penable_q, err_q, err_valid_q;
  logic [SLV_NUM-1:0] psel_q;
  logic [1:0]         cause_q, err_cause_q;
  logic               sel_ready, sel_err, timeout_hit;
  logic [31:0]        sel_rdata;

  assign off      = mmap_addr_i - ADDR_BASE;
  assign idx_full = off >> SLV_SHIFT;
  assign hit      = (mmap_addr_i >= ADDR_BASE) && (idx_full < SLV_NUM);

  assign sel_ready = apb_pready_i[idx_q];
  assign sel_err   = apb_pslverr_i[idx_q];
  assign sel_rdata = apb_prdata_i[idx_q*32 +: 32];
  // A pready in the final counted cycle takes priority over the abort.
  assign timeout_hit = (TIMEOUT_CYC != 0) && !sel_ready && (tcnt_q + 32'd1 == TIMEOUT_CYC);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mmap_valid_i) state_d = hit ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (sel_ready || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      tcnt_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cause_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (mmap_valid_i) begin
          paddr_q  <= mmap_addr_i;
          pwdata_q <= mmap_wdata_i;
          pstrb_q  <= mmap_wstrb_i;
          pwrite_q <= |mmap_wstrb_i;
          if (hit) begin
            idx_q  <= idx_full[IDX_W-1:0];
            psel_q <= SEL_ONE << idx_full[IDX_W-1:0];
          end else begin
            rdata_q <= ERR_RDATA;
            err_q   <= 1'b1;
            cause_q <= 2'b01;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          tcnt_q    <= '0;
        end
        ACCESS: begin
          if (sel_ready) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            err_q     <= sel_err;
            cause_q   <= sel_err ? 2'b10 : 2'b00;
            rdata_q   <= sel_err ? ERR_RDATA : (pwrite_q ? 32'h0 : sel_rdata);
          end else if (timeout_hit) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            err_q     <= 1'b1;
            cause_q   <= 2'b11;
            rdata_q   <= ERR_RDATA;
          end else begin
            tcnt_q <= tcnt_q + 32'd1;
          end
        end
        RESP: begin
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // First error is held; a clear coinciding with a new error re-arms with the new one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_valid_q <= 1'b0;
      err_cause_q <= '0;
      err_addr_q  <= '0;
    end else if (state_q == RESP && err_q && (!err_valid_q || err_clr_i)) begin
      err_valid_q <= 1'b1;
      err_cause_q <= cause_q;
      err_addr_q  <= paddr_q;
    end else if (err_clr_i) begin
      err_valid_q <= 1'b0;
      err_cause_q <= '0;
      err_addr_q  <= '0;
    end
  end

  assign mmap_ready_o  = (state_q == RESP);
  assign mmap_err_o    = err_q;
  assign mmap_rdata_o  = rdata_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_pprot_o   = 3'b010;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_pwdata_o  = pwdata_q;
  assign apb_pstrb_o   = pstrb_q;
  assign err_valid_o   = err_valid_q;
  assign err_cause_o   = err_cause_q;
  assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_mmap_apb_bridge_n.sv
// tb/tb_mmap_apb_bridge_n.sv - scoreboard bench for mmap_apb_bridge_n
module tb_mmap_apb_bridge_n;
  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic          clk_i = 0, rst_n_i = 0;
  logic          mmap_valid_i = 0;
  logic [31:0]   mmap_addr_i = 0, mmap_wdata_i = 0;
  logic [3:0]    mmap_wstrb_i = 0;
  logic [31:0]   mmap_rdata_o;
  logic          mmap_ready_o, mmap_err_o;
  logic [31:0]   apb_paddr_o, apb_pwdata_o;
  logic [2:0]    apb_pprot_o;
  logic [N-1:0]  apb_psel_o, apb_pready_i, apb_pslverr_i;
  logic          apb_penable_o, apb_pwrite_o;
  logic [3:0]    apb_pstrb_o;
  logic [32*N-1:0] apb_prdata_i;
  logic          err_clr_i = 0, err_valid_o;
  logic [1:0]    err_cause_o;
  logic [31:0]   err_addr_o;

  mmap_apb_bridge_n dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .mmap_valid_i(mmap_valid_i), .mmap_addr_i(mmap_addr_i), .mmap_wdata_i(mmap_wdata_i),
    .mmap_wstrb_i(mmap_wstrb_i), .mmap_rdata_o(mmap_rdata_o), .mmap_ready_o(mmap_ready_o),
    .mmap_err_o(mmap_err_o), .apb_paddr_o(apb_paddr_o), .apb_pprot_o(apb_pprot_o),
    .apb_psel_o(apb_psel_o), .apb_penable_o(apb_penable_o), .apb_pwrite_o(apb_pwrite_o),
    .apb_pwdata_o(apb_pwdata_o), .apb_pstrb_o(apb_pstrb_o), .apb_pready_i(apb_pready_i),
    .apb_prdata_i(apb_prdata_i), .apb_pslverr_i(apb_pslverr_i), .err_clr_i(err_clr_i),
    .err_valid_o(err_valid_o), .err_cause_o(err_cause_o), .err_addr_o(err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  // Slave model: wait_cfg < 0 means the slave never answers.
  int          wait_cfg [N];
  logic        slverr_cfg [N];
  logic [31:0] prdata_cfg [N];
  int          acc_cnt = 0;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      apb_pready_i[k]  = apb_psel_o[k] && apb_penable_o && (wait_cfg[k] >= 0) && (acc_cnt == wait_cfg[k]);
      apb_pslverr_i[k] = apb_pready_i[k] && slverr_cfg[k];
      apb_prdata_i[k*32 +: 32] = prdata_cfg[k];
    end
  end

  always @(posedge clk_i) begin
    if (apb_penable_o && !(|apb_pready_i)) acc_cnt <= acc_cnt + 1;
    else                                   acc_cnt <= 0;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          pen;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic run_xfer(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input logic [N-1:0] exp_psel, input int exp_pen);
    exp_t e;
    int   cyc, pen;
    logic got;
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.pen = exp_pen;
    sb.push_back(e);
    @(posedge clk_i); #1;
    mmap_valid_i = 1; mmap_addr_i = addr; mmap_wdata_i = wdata; mmap_wstrb_i = wstrb;
    cyc = 0; pen = 0; got = 0;
    while (!got && cyc < 400) begin
      @(posedge clk_i); #1;
      cyc++;
      if (cyc == 1) begin
        n_tests++;
        if (apb_psel_o !== exp_psel || apb_penable_o !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_setup psel=%b penable=%b expected psel=%b penable=0", name, apb_psel_o, apb_penable_o, exp_psel);
        end
        if (exp_psel != 0) begin
          n_tests++;
          if (apb_paddr_o !== addr || apb_pwrite_o !== (|wstrb) || apb_pstrb_o !== wstrb || apb_pwdata_o !== wdata) begin
            n_fail++;
            $display("FAIL %s_apbctl paddr=%h pwrite=%b pstrb=%b pwdata=%h expected %h %b %b %h",
                     name, apb_paddr_o, apb_pwrite_o, apb_pstrb_o, apb_pwdata_o, addr, |wstrb, wstrb, wdata);
          end
        end
      end
      if (apb_penable_o) pen++;
      if (mmap_ready_o) got = 1;
    end
    mmap_valid_i = 0;
    e = sb.pop_front();
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_timeout no ready after %0d cycles, expected ready at %0d", name, cyc, e.lat);
    end else if (mmap_rdata_o !== e.rdata || mmap_err_o !== e.err || cyc != e.lat || pen != e.pen || apb_psel_o !== '0) begin
      n_fail++;
      $display("FAIL %s_resp rdata=%h err=%b lat=%0d pen=%0d psel=%b expected rdata=%h err=%b lat=%0d pen=%0d psel=0",
               name, mmap_rdata_o, mmap_err_o, cyc, pen, apb_psel_o, e.rdata, e.err, e.lat, e.pen);
    end
  endtask

  task automatic check_err(input string name, input logic v, input logic [1:0] c, input logic [31:0] a);
    n_tests++;
    if (err_valid_o !== v || err_cause_o !== c || err_addr_o !== a) begin
      n_fail++;
      $display("FAIL %s valid=%b cause=%b addr=%h expected %b %b %h", name, err_valid_o, err_cause_o, err_addr_o, v, c, a);
    end
  endtask

  task automatic pulse_clr();
    err_clr_i = 1;
    @(posedge clk_i); #1;
    err_clr_i = 0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      wait_cfg[k] = 0; slverr_cfg[k] = 0; prdata_cfg[k] = 32'hA000_0000 + k;
    end
    rst_n_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    n_tests++;
    if (mmap_ready_o !== 0 || mmap_err_o !== 0 || mmap_rdata_o !== 0 || apb_psel_o !== 0 ||
        apb_penable_o !== 0 || err_valid_o !== 0 || err_cause_o !== 0 || err_addr_o !== 0) begin
      n_fail++;
      $display("FAIL reset ready=%b err=%b rdata=%h psel=%b pen=%b errv=%b expected all 0",
               mmap_ready_o, mmap_err_o, mmap_rdata_o, apb_psel_o, apb_penable_o, err_valid_o);
    end
    @(negedge clk_i) rst_n_i = 1;
  endtask

  task automatic test_read();
    prdata_cfg[2] = 32'h1234_5678;
    run_xfer("read_s2", BASE + 32'h2004, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3, 8'b0000_0100, 1);
    @(posedge clk_i); #1;
    n_tests++;
    if (mmap_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_pulse ready=%b expected 0", mmap_ready_o);
    end
    check_err("read_no_err", 1'b0, 2'b00, 32'h0);
  endtask

  task automatic test_write_wait();
    wait_cfg[0] = 2;
    run_xfer("write_s0", BASE + 32'h10, 32'hA5A5_0000, 4'b1100, 32'h0, 1'b0, 5, 8'b0000_0001, 3);
    wait_cfg[0] = 0;
  endtask

  task automatic test_boundary();
    prdata_cfg[7] = 32'h7777_0001;
    run_xfer("last_byte_s7", BASE + 32'h7FFF, 32'h0, 4'h0, 32'h7777_0001, 1'b0, 3, 8'b1000_0000, 1);
    run_xfer("below_base", BASE - 32'h4, 32'h0, 4'h0, ERRD, 1'b1, 1, 8'h00, 0);
    @(posedge clk_i); #1;
    check_err("below_base_cap", 1'b1, 2'b01, BASE - 32'h4);
    pulse_clr();
    check_err("clr_after_below", 1'b0, 2'b00, 32'h0);
  endtask

  task automatic test_miss();
    run_xfer("miss", BASE + 32'h8000, 32'h1, 4'hF, ERRD, 1'b1, 1, 8'h00, 0);
    @(posedge clk_i); #1;
    check_err("miss_cap", 1'b1, 2'b01, BASE + 32'h8000);
    pulse_clr();
  endtask

  task automatic test_timeout();
    wait_cfg[5] = -1;
    run_xfer("timeout_s5", BASE + 32'h5000, 32'h0, 4'h0, ERRD, 1'b1, 257, 8'b0010_0000, 255);
    @(posedge clk_i); #1;
    check_err("timeout_cap", 1'b1, 2'b11, BASE + 32'h5000);
    wait_cfg[5] = 0;
    pulse_clr();
  endtask

  task automatic test_slverr();
    slverr_cfg[1] = 1;
    run_xfer("slverr_s1", BASE + 32'h1008, 32'h0, 4'h0, ERRD, 1'b1, 3, 8'b0000_0010, 1);
    slverr_cfg[1] = 0;
    @(posedge clk_i); #1;
    check_err("slverr_cap", 1'b1, 2'b10, BASE + 32'h1008);
    run_xfer("second_err", BASE + 32'h9000, 32'h0, 4'h0, ERRD, 1'b1, 1, 8'h00, 0);
    @(posedge clk_i); #1;
    check_err("first_err_kept", 1'b1, 2'b10, BASE + 32'h1008);
    run_xfer("clr_race", BASE + 32'hA000, 32'h0, 4'h0, ERRD, 1'b1, 1, 8'h00, 0);
    pulse_clr();
    check_err("clr_race_newwins", 1'b1, 2'b01, BASE + 32'hA000);
    pulse_clr();
    check_err("clr_only", 1'b0, 2'b00, 32'h0);
  endtask

  task automatic test_reset_mid();
    wait_cfg[3] = -1;
    @(posedge clk_i); #1;
    mmap_valid_i = 1; mmap_addr_i = BASE + 32'h3000; mmap_wstrb_i = 4'h0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_n_i = 0;
    #1;
    n_tests++;
    if (apb_psel_o !== 0 || apb_penable_o !== 0 || mmap_ready_o !== 0) begin
      n_fail++;
      $display("FAIL reset_mid psel=%b pen=%b ready=%b expected 0", apb_psel_o, apb_penable_o, mmap_ready_o);
    end
    mmap_valid_i = 0;
    wait_cfg[3] = 0;
    prdata_cfg[3] = 32'h3333_CAFE;
    @(negedge clk_i) rst_n_i = 1;
    run_xfer("after_reset_s3", BASE + 32'h3000, 32'h0, 4'h0, 32'h3333_CAFE, 1'b0, 3, 8'b0000_1000, 1);
  endtask

  task automatic test_back_to_back();
    prdata_cfg[6] = 32'h6666_0606;
    wait_cfg[4] = 1;
    run_xfer("b2b_rd_s6", BASE + 32'h6100, 32'h0, 4'h0, 32'h6666_0606, 1'b0, 3, 8'b0100_0000, 1);
    run_xfer("b2b_wr_s4", BASE + 32'h4FFC, 32'h0BAD_F00D, 4'b0001, 32'h0, 1'b0, 4, 8'b0001_0000, 2);
    wait_cfg[4] = 0;
    check_err("b2b_no_err", 1'b0, 2'b00, 32'h0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_boundary();
    test_miss();
    test_timeout();
    test_slverr();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
